// File: rtl/fsk_pkg.sv
// ============================================================================
// fsk_pkg : shared state encoding and window-length / threshold helpers
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package fsk_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HUNT  = 3'd1,
    START = 3'd2,
    ALIGN = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  function automatic int unsigned bit_ticks(input int unsigned clock_hz,
                                            input int unsigned rate);
    return clock_hz / rate;
  endfunction

  function automatic int unsigned q_ticks(input int unsigned bit_len);
    return bit_len / 4;
  endfunction

  function automatic int unsigned occupancy_threshold(input int unsigned len,
                                                      input int unsigned pct);
    return (len * pct) / 100;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fsk_window_evaluator.sv
// ============================================================================
// fsk_window_evaluator : per-window occupancy check and mark/space decision
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fsk_window_evaluator (
  input  logic [31:0] f0_value,
  input  logic [31:0] f1_value,
  input  logic [31:0] s0,
  input  logic [31:0] s1,
  input  logic [31:0] threshold,
  output logic        valid,
  output logic        bit_value
);

  logic [31:0] d0;
  logic [31:0] d1;
  logic [32:0] d_sum;

  // Modulo subtraction keeps accumulator wrap invisible to the decision.
  assign d0        = f0_value - s0;
  assign d1        = f1_value - s1;
  assign d_sum     = {1'b0, d0} + {1'b0, d1};
  assign valid     = (d_sum >= {1'b0, threshold});
  assign bit_value = (d1 >= d0);

endmodule

`default_nettype wire

// File: rtl/fsk_bit_decoder.sv
// ============================================================================
// fsk_bit_decoder : windowed FSK bit slicer with UART framing and byte port
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fsk_bit_decoder
  import fsk_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned BIT_RATE        = 1000,
  parameter int unsigned MIN_OCCUPANCY   = 50
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] f0_value,
  input  logic [31:0] f1_value,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        framing_error,
  output logic        carrier_error,
  output logic        overflow,
  output logic        busy
);

  localparam int unsigned BIT_TICKS = bit_ticks(CLOCK_FREQUENCY, BIT_RATE);
  localparam int unsigned Q_TICKS   = q_ticks(BIT_TICKS);
  localparam int unsigned TH_Q      = occupancy_threshold(Q_TICKS, MIN_OCCUPANCY);
  localparam int unsigned TH_2Q     = occupancy_threshold(2 * Q_TICKS, MIN_OCCUPANCY);
  localparam int unsigned TH_BIT    = occupancy_threshold(BIT_TICKS, MIN_OCCUPANCY);

  state_t      state;
  state_t      state_next;
  logic [31:0] s0;
  logic [31:0] s1;
  logic [31:0] tick;
  logic [2:0]  index;
  logic [7:0]  shift;

  logic [31:0] win_len;
  logic [31:0] threshold;
  logic        last_tick;
  logic        win_valid;
  logic        win_bit;
  logic        framing_next;
  logic        carrier_next;
  logic        complete;
  logic        handshake;

  fsk_window_evaluator u_eval (
    .f0_value  (f0_value),
    .f1_value  (f1_value),
    .s0        (s0),
    .s1        (s1),
    .threshold (threshold),
    .valid     (win_valid),
    .bit_value (win_bit)
  );

  always_comb begin
    win_len   = BIT_TICKS;
    threshold = TH_BIT;
    case (state)
      HUNT, START: begin
        win_len   = Q_TICKS;
        threshold = TH_Q;
      end
      ALIGN: begin
        win_len   = 2 * Q_TICKS;
        threshold = TH_2Q;
      end
      default: ;
    endcase
  end

  assign last_tick = (state != IDLE) && (tick == win_len - 32'd1);
  assign busy      = (state == START) || (state == ALIGN) ||
                     (state == DATA)  || (state == STOP);
  assign handshake = byte_valid && byte_ready;

  always_comb begin
    state_next   = state;
    framing_next = 1'b0;
    carrier_next = 1'b0;
    complete     = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: state_next = HUNT;
        HUNT: begin
          if (last_tick && win_valid && !win_bit) state_next = START;
        end
        START: begin
          if (last_tick) begin
            if (!win_valid) begin
              carrier_next = 1'b1;
              state_next   = HUNT;
            end else if (win_bit) begin
              state_next = HUNT;
            end else begin
              state_next = ALIGN;
            end
          end
        end
        ALIGN: begin
          if (last_tick) state_next = DATA;
        end
        DATA: begin
          if (last_tick) begin
            if (!win_valid) begin
              carrier_next = 1'b1;
              state_next   = HUNT;
            end else if (index == 3'd7) begin
              state_next = STOP;
            end
          end
        end
        STOP: begin
          if (last_tick) begin
            state_next = HUNT;
            if (!win_valid)   carrier_next = 1'b1;
            else if (win_bit) complete     = 1'b1;
            else              framing_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state         <= IDLE;
      s0            <= 32'd0;
      s1            <= 32'd0;
      tick          <= 32'd0;
      index         <= 3'd0;
      shift         <= 8'd0;
      framing_error <= 1'b0;
      carrier_error <= 1'b0;
    end else begin
      state         <= state_next;
      framing_error <= framing_next;
      carrier_error <= carrier_next;

      // Snapshots follow the inputs in IDLE so the first HUNT window starts clean.
      if (state == IDLE || last_tick) begin
        s0   <= f0_value;
        s1   <= f1_value;
        tick <= 32'd0;
      end else begin
        tick <= tick + 32'd1;
      end

      if (!enable) begin
        tick  <= 32'd0;
        index <= 3'd0;
        shift <= 8'd0;
      end else if (state == ALIGN && last_tick) begin
        index <= 3'd0;
        shift <= 8'd0;
      end else if (state == DATA && last_tick && win_valid) begin
        shift[index] <= win_bit;
        index        <= index + 3'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      byte_data  <= 8'd0;
      byte_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (complete) begin
        if (!byte_valid || handshake) begin
          byte_data  <= shift;
          byte_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (handshake) begin
        byte_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fsk_bit_decoder.sv
// ============================================================================
// tb_fsk_bit_decoder : directed frames with a scoreboard-driven output monitor
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fsk_bit_decoder;

  localparam int EV_BYTE = 0;
  localparam int EV_FRM  = 1;
  localparam int EV_CAR  = 2;
  localparam int EV_OVF  = 3;
  localparam int SPACE   = 0;
  localparam int MARK    = 1;
  localparam int NONE    = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic        clock = 1'b0;
  logic        clear;
  logic        enable;
  logic [31:0] f0_value;
  logic [31:0] f1_value;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        framing_error;
  logic        carrier_error;
  logic        overflow;
  logic        busy;

  int  tests = 0;
  int  fails = 0;
  ev_t sb[$];

  fsk_bit_decoder #(
    .CLOCK_FREQUENCY (400000),
    .BIT_RATE        (1000),
    .MIN_OCCUPANCY   (50)
  ) dut (
    .clock         (clock),
    .clear         (clear),
    .enable        (enable),
    .f0_value      (f0_value),
    .f1_value      (f1_value),
    .byte_data     (byte_data),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .framing_error (framing_error),
    .carrier_error (carrier_error),
    .overflow      (overflow),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic expect_event(input int kind, input logic [7:0] data);
    ev_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind %0d data %h, expected no event", kind, data);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || (kind == EV_BYTE && e.data !== data)) begin
        fails++;
        $display("FAIL event: got kind %0d data %h, expected kind %0d data %h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  // Analyzer model: one tick per clock on the active tone's accumulator.
  task automatic tone(input int t, input int n);
    repeat (n) begin
      @(negedge clock);
      if (t == SPACE)     f0_value = f0_value + 32'd1;
      else if (t == MARK) f1_value = f1_value + 32'd1;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    tone(SPACE, 400);
    for (int i = 0; i < nbits; i++) tone(b[i] ? MARK : SPACE, 400);
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_tone);
    send_bits(b, 8);
    tone(stop_tone, 400);
  endtask

  task automatic sample;
    @(posedge clock);
    #1;
  endtask

  task automatic consume(input string name, input logic [7:0] exp);
    sample();
    check({name, "_valid"}, {31'd0, byte_valid}, 32'd1);
    check({name, "_data"}, {24'd0, byte_data}, {24'd0, exp});
    @(negedge clock);
    byte_ready = 1'b1;
    @(negedge clock);
    byte_ready = 1'b0;
    sample();
    check({name, "_drained"}, {31'd0, byte_valid}, 32'd0);
  endtask

  // Monitor: every output event pops the scoreboard; pulses must be one cycle.
  initial begin
    logic prev_valid;
    logic prev_frm;
    logic prev_car;
    logic prev_ovf;
    prev_valid = 1'b0;
    prev_frm   = 1'b0;
    prev_car   = 1'b0;
    prev_ovf   = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!clear) begin
        if (byte_valid && !prev_valid) expect_event(EV_BYTE, byte_data);
        if (framing_error) begin
          expect_event(EV_FRM, 8'd0);
          check("framing_width", {31'd0, prev_frm}, 32'd0);
        end
        if (carrier_error) begin
          expect_event(EV_CAR, 8'd0);
          check("carrier_width", {31'd0, prev_car}, 32'd0);
        end
        if (overflow) begin
          expect_event(EV_OVF, 8'd0);
          check("overflow_width", {31'd0, prev_ovf}, 32'd0);
        end
      end
      prev_valid = byte_valid;
      prev_frm   = framing_error;
      prev_car   = carrier_error;
      prev_ovf   = overflow;
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    clear      = 1'b1;
    enable     = 1'b0;
    byte_ready = 1'b0;
    f0_value   = 32'd0;
    f1_value   = 32'd0;
    repeat (3) @(negedge clock);
    sample();
    check("reset_outputs",
          {24'd0, byte_valid, framing_error, carrier_error, overflow, busy, 3'd0},
          32'd0);
    check("reset_data", {24'd0, byte_data}, 32'd0);
    @(negedge clock);
    clear  = 1'b0;
    enable = 1'b1;

    // 1: single clean frame
    tone(MARK, 300);
    push(EV_BYTE, 8'h5A);
    send_frame(8'h5A, MARK);
    tone(MARK, 400);
    consume("t1", 8'h5A);

    // 2: back-to-back frames into a full holding register
    push(EV_BYTE, 8'h01);
    push(EV_OVF, 8'd0);
    send_frame(8'h01, MARK);
    send_frame(8'hFF, MARK);
    tone(MARK, 400);
    consume("t2", 8'h01);

    // 3: stop bit sent as space
    push(EV_FRM, 8'd0);
    tone(MARK, 250);
    send_frame(8'h33, SPACE);
    tone(MARK, 400);
    sample();
    check("t3_valid", {31'd0, byte_valid}, 32'd0);
    check("t3_hunt_not_busy", {31'd0, busy}, 32'd0);

    // 4: carrier lost from data bit 3, then recovery
    push(EV_CAR, 8'd0);
    tone(MARK, 170);
    send_bits(8'hFF, 3);
    tone(NONE, 1200);
    sample();
    check("t4_not_busy", {31'd0, busy}, 32'd0);
    tone(MARK, 200);
    push(EV_BYTE, 8'hC3);
    send_frame(8'hC3, MARK);
    tone(MARK, 400);
    consume("t4", 8'hC3);

    // 5: mark accumulator wraps during data bit 7
    @(negedge clock);
    f1_value = 32'hFFFF_FF00;
    tone(MARK, 150);
    push(EV_BYTE, 8'h80);
    send_frame(8'h80, MARK);
    tone(MARK, 400);
    consume("t5", 8'h80);

    // 6a: enable dropped during data bit 5
    tone(MARK, 120);
    send_bits(8'h2D, 5);
    tone(SPACE, 200);
    sample();
    check("t6_busy_mid_frame", {31'd0, busy}, 32'd1);
    @(negedge clock);
    enable = 1'b0;
    tone(MARK, 50);
    sample();
    check("t6_idle_not_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    enable = 1'b1;
    tone(MARK, 300);

    // 6b: clear while a byte is held and another frame is in flight
    push(EV_BYTE, 8'h7E);
    send_frame(8'h7E, MARK);
    tone(MARK, 300);
    send_bits(8'h55, 2);
    sample();
    check("t6_busy_before_clear", {31'd0, busy}, 32'd1);
    @(negedge clock);
    clear = 1'b1;
    sample();
    check("t6_clear_outputs",
          {24'd0, byte_valid, framing_error, carrier_error, overflow, busy, 3'd0},
          32'd0);
    check("t6_clear_data", {24'd0, byte_data}, 32'd0);
    @(negedge clock);
    clear = 1'b0;
    tone(MARK, 600);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
